// File: rtl/nco_voice_bank_if.sv
// Config write handshake and per-voice result bus of the NCO voice bank.
interface nco_voice_bank_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned VW    = 2,
  parameter int unsigned IDX_W = 9
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [VW-1:0]    cfg_voice;
  logic [ACC_W-1:0] cfg_tune;
  logic             cfg_gate;
  logic             cfg_err;
  logic             out_valid;
  logic [VW-1:0]    out_voice;
  logic [IDX_W-1:0] out_index;
  logic             out_wrap;

  modport master (
    output cfg_valid, cfg_voice, cfg_tune, cfg_gate,
    input  cfg_ready, cfg_err, out_valid, out_voice, out_index, out_wrap
  );

  modport slave (
    input  cfg_valid, cfg_voice, cfg_tune, cfg_gate,
    output cfg_ready, cfg_err, out_valid, out_voice, out_index, out_wrap
  );
endinterface

// File: rtl/nco_voice_bank.sv
// Multi-voice phase-accumulator NCO; voices are swept one per cycle after each sample tick
// and each result is scaled into a 0..TBL_LEN-1 lookup-table index.
module nco_voice_bank #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned PH_W       = 12,
  parameter int unsigned TBL_LEN    = 360,
  parameter int unsigned IDX_W      = 9,
  parameter int unsigned SAMPLE_DIV = 256,
  parameter int unsigned VW         = 2
) (
  input logic              clk,
  input logic              rst,
  input logic              en,
  input logic              sync,
  nco_voice_bank_if.slave  bus
);

  localparam int unsigned CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned PROD_W = PH_W + IDX_W + 1;

  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q;
  logic [VW-1:0]         ptr_q;
  logic                  sync_pending_q;
  logic                  sweep_zero_q;
  logic [ACC_W-1:0]      acc_q  [NUM_VOICES];
  logic [ACC_W-1:0]      tune_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;

  logic                  out_valid_q;
  logic [VW-1:0]         out_voice_q;
  logic [IDX_W-1:0]      out_index_q;
  logic                  out_wrap_q;
  logic                  cfg_err_q;

  logic                  tick;
  logic                  cfg_ready;
  logic                  cfg_fire;
  logic                  cfg_in_range;
  logic                  last_voice;

  logic [ACC_W-1:0]      cur_acc;
  logic [ACC_W:0]        sum;
  logic [ACC_W-1:0]      new_acc;
  logic                  new_wrap;
  logic [PROD_W-1:0]     prod;
  logic [IDX_W-1:0]      new_index;

  assign tick         = en && (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign cfg_ready    = !busy_q && !rst;
  assign cfg_fire     = bus.cfg_valid && cfg_ready;
  assign cfg_in_range = 32'(bus.cfg_voice) < NUM_VOICES;
  assign last_voice   = (ptr_q == VW'(NUM_VOICES - 1));

  // Update of the voice currently addressed by the sweep pointer.
  always_comb begin
    cur_acc  = acc_q[ptr_q];
    sum      = {1'b0, cur_acc} + {1'b0, tune_q[ptr_q]};
    new_acc  = cur_acc;
    new_wrap = 1'b0;
    if (sweep_zero_q) begin
      new_acc  = '0;
      new_wrap = 1'b0;
    end else if (gate_q[ptr_q]) begin
      new_acc  = sum[ACC_W-1:0];
      new_wrap = sum[ACC_W];
    end
    // top phase bits * TBL_LEN / 2^PH_W stays strictly below TBL_LEN
    prod      = PROD_W'(new_acc[ACC_W-1 -: PH_W]) * PROD_W'(TBL_LEN);
    new_index = IDX_W'(prod >> PH_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      ptr_q          <= '0;
      sync_pending_q <= 1'b0;
      sweep_zero_q   <= 1'b0;
      gate_q         <= '0;
      out_valid_q    <= 1'b0;
      out_voice_q    <= '0;
      out_index_q    <= '0;
      out_wrap_q     <= 1'b0;
      cfg_err_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        acc_q[i]  <= '0;
        tune_q[i] <= '0;
      end
    end else begin
      if (en) begin
        cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      end

      // A sync seen up to and including the tick cycle zeroes the sweep that follows.
      if (tick) begin
        sweep_zero_q   <= sync_pending_q || sync;
        sync_pending_q <= 1'b0;
      end else if (sync) begin
        sync_pending_q <= 1'b1;
      end

      out_valid_q <= busy_q;
      if (busy_q) begin
        acc_q[ptr_q] <= new_acc;
        out_voice_q  <= ptr_q;
        out_index_q  <= new_index;
        out_wrap_q   <= new_wrap;
        if (last_voice) begin
          busy_q <= 1'b0;
        end else begin
          ptr_q <= ptr_q + VW'(1);
        end
      end else if (tick) begin
        busy_q <= 1'b1;
        ptr_q  <= '0;
      end

      cfg_err_q <= cfg_fire && !cfg_in_range;
      if (cfg_fire && cfg_in_range) begin
        tune_q[bus.cfg_voice] <= bus.cfg_tune;
        gate_q[bus.cfg_voice] <= bus.cfg_gate;
      end
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_voice = out_voice_q;
  assign bus.out_index = out_index_q;
  assign bus.out_wrap  = out_wrap_q;

endmodule

// File: tb/tb_nco_voice_bank.sv
// Directed bench for nco_voice_bank: a 4-voice instance (fast tick) and a 3-voice instance
// for out-of-range config writes.
module tb_nco_voice_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, sync_a = 1'b0;
  logic en_b = 1'b0, sync_b = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] g_idx   [4];
  logic [31:0] g_wrap  [4];
  logic [31:0] g_voice [4];

  nco_voice_bank_if #(.ACC_W(24), .VW(2), .IDX_W(9)) ifa ();
  nco_voice_bank_if #(.ACC_W(24), .VW(2), .IDX_W(9)) ifb ();

  nco_voice_bank #(
    .NUM_VOICES(4), .ACC_W(24), .PH_W(12), .TBL_LEN(360), .IDX_W(9), .SAMPLE_DIV(16), .VW(2)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .en  (en_a),
    .sync(sync_a),
    .bus (ifa)
  );

  nco_voice_bank #(
    .NUM_VOICES(3), .ACC_W(24), .PH_W(12), .TBL_LEN(360), .IDX_W(9), .SAMPLE_DIV(8), .VW(2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .en  (en_b),
    .sync(sync_b),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic cfg_write(input bit sel, input logic [1:0] voice, input logic [23:0] tune,
                           input logic gate);
    int n = 0;
    while (((sel ? ifb.cfg_ready : ifa.cfg_ready) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cfg_ready_wait", sel ? ifb.cfg_ready : ifa.cfg_ready, 1);
    if (sel) begin
      ifb.cfg_valid = 1'b1; ifb.cfg_voice = voice; ifb.cfg_tune = tune; ifb.cfg_gate = gate;
    end else begin
      ifa.cfg_valid = 1'b1; ifa.cfg_voice = voice; ifa.cfg_tune = tune; ifa.cfg_gate = gate;
    end
    @(negedge clk);
    ifa.cfg_valid = 1'b0;
    ifb.cfg_valid = 1'b0;
  endtask

  // Collect one full sweep of dut_a; optionally pulse sync after the first result.
  task automatic collect(input bit pulse_sync);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifa.out_valid !== 1'b1 && n < 100);
    check("sweep_start", ifa.out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("sweep_valid", ifa.out_valid, 1);
      g_idx[i]   = 32'(ifa.out_index);
      g_wrap[i]  = 32'(ifa.out_wrap);
      g_voice[i] = 32'(ifa.out_voice);
      if (pulse_sync && i == 0) sync_a = 1'b1;
      if (pulse_sync && i == 1) sync_a = 1'b0;
    end
    @(negedge clk);
    check("sweep_end", ifa.out_valid, 0);
  endtask

  initial begin
    int n;
    int zeros;
    int pulses;
    bit drop;
    logic [31:0] v2_idx;
    logic [31:0] exp_idx;

    ifa.cfg_valid = 1'b0; ifa.cfg_voice = '0; ifa.cfg_tune = '0; ifa.cfg_gate = 1'b0;
    ifb.cfg_valid = 1'b0; ifb.cfg_voice = '0; ifb.cfg_tune = '0; ifb.cfg_gate = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",     ifa.cfg_ready, 0);
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_out_voice", ifa.out_voice, 0);
    check("rst_out_index", ifa.out_index, 0);
    check("rst_out_wrap",  ifa.out_wrap,  0);
    check("rst_cfg_err",   ifa.cfg_err,   0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ifa.cfg_ready, 1);

    // Voice 0 at 1/256 of full scale: 256 samples per cycle of the index
    cfg_write(1'b0, 2'd0, 24'h010000, 1'b1);
    en_a = 1'b1;
    for (int s = 1; s <= 256; s++) begin
      collect(1'b0);
      exp_idx = (((s * 16) % 4096) * 360) >> 12;
      check("v0_ramp_idx",  g_idx[0],  exp_idx);
      check("v0_ramp_wrap", g_wrap[0], (s == 256) ? 1 : 0);
      if (s == 1) begin
        check("s1_idx", g_idx[0], 1);
        for (int v = 0; v < 4; v++) check("s1_voice", g_voice[v], v);
        for (int v = 1; v < 4; v++) check("s1_idle_idx", g_idx[v], 0);
      end
      if (s == 255) check("s255_idx", g_idx[0], 358);
      if (s == 256) check("s256_idx", g_idx[0], 0);
    end

    // Near-full-scale tuning word: wraps on every update after the first
    cfg_write(1'b0, 2'd1, 24'hFFFFFF, 1'b1);
    collect(1'b0);
    check("v1_first_idx",  g_idx[1],  359);
    check("v1_first_wrap", g_wrap[1], 0);
    check("v0_s257_idx",   g_idx[0],  1);
    collect(1'b0);
    check("v1_second_idx",  g_idx[1],  359);
    check("v1_second_wrap", g_wrap[1], 1);
    check("v0_s258_idx",    g_idx[0],  2);

    // Gate off freezes phase, gate on resumes from it
    cfg_write(1'b0, 2'd0, 24'h010000, 1'b0);
    collect(1'b0);
    check("gate_off_idx1",  g_idx[0],  2);
    check("gate_off_wrap1", g_wrap[0], 0);
    collect(1'b0);
    check("gate_off_idx2",  g_idx[0],  2);
    cfg_write(1'b0, 2'd0, 24'h010000, 1'b1);
    collect(1'b0);
    check("gate_on_idx", g_idx[0], 4);

    // Config write held across a tick waits out the sweep
    n = 0;
    while (ifa.cfg_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (ifa.cfg_ready !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("busy_seen", ifa.cfg_ready, 0);
    ifa.cfg_valid = 1'b1; ifa.cfg_voice = 2'd2; ifa.cfg_tune = 24'h100000; ifa.cfg_gate = 1'b1;
    zeros = 0; pulses = 0; drop = 1'b0; v2_idx = 32'hFFFF;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (drop) begin ifa.cfg_valid = 1'b0; drop = 1'b0; end
      if (ifa.cfg_ready === 1'b0) zeros++;
      if (ifa.out_valid === 1'b1) begin
        check("held_voice_order", ifa.out_voice, pulses);
        if (ifa.out_voice == 2'd2) v2_idx = 32'(ifa.out_index);
        pulses++;
      end
      if (ifa.cfg_valid && ifa.cfg_ready === 1'b1) drop = 1'b1;
    end
    ifa.cfg_valid = 1'b0;
    check("held_ready_low", zeros,  4);
    check("held_pulses",    pulses, 4);
    check("held_v2_before", v2_idx, 0);

    // Sync mid-sweep: this sweep unaffected, next one zeroed, then restart from 0
    collect(1'b1);
    check("sync_cur_v0_idx",  g_idx[0],  7);
    check("sync_cur_v1_idx",  g_idx[1],  359);
    check("sync_cur_v1_wrap", g_wrap[1], 1);
    check("sync_cur_v2_idx",  g_idx[2],  22);
    collect(1'b0);
    for (int v = 0; v < 4; v++) begin
      check("sync_zero_idx",  g_idx[v],  0);
      check("sync_zero_wrap", g_wrap[v], 0);
    end
    collect(1'b0);
    check("resync_v0_idx",  g_idx[0],  1);
    check("resync_v1_idx",  g_idx[1],  359);
    check("resync_v1_wrap", g_wrap[1], 0);
    check("resync_v2_idx",  g_idx[2],  22);
    check("resync_v3_idx",  g_idx[3],  0);

    // Out-of-range voice on the 3-voice instance
    cfg_write(1'b1, 2'd3, 24'h123456, 1'b1);
    check("err_pulse", ifb.cfg_err, 1);
    @(negedge clk);
    check("err_clear", ifb.cfg_err, 0);
    cfg_write(1'b1, 2'd0, 24'h400000, 1'b1);
    check("err_valid_write", ifb.cfg_err, 0);
    en_b = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ifb.out_valid !== 1'b1 && n < 100);
    check("b_sweep_start", ifb.out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("b_valid", ifb.out_valid, 1);
      check("b_voice", ifb.out_voice, i);
      check("b_idx",   ifb.out_index, (i == 0) ? 90 : 0);
    end
    @(negedge clk);
    check("b_sweep_end", ifb.out_valid, 0);

    // Reset in the middle of a sweep
    n = 0;
    while (ifa.cfg_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (ifa.cfg_ready !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("busy_before_rst", ifa.cfg_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", ifa.out_valid, 0);
    check("midrst_ready",     ifa.cfg_ready, 0);
    check("midrst_out_index", ifa.out_index, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", ifa.cfg_ready, 1);
    check("midrst_no_valid",   ifa.out_valid, 0);
    collect(1'b0);
    for (int v = 0; v < 4; v++) begin
      check("after_rst_voice", g_voice[v], v);
      check("after_rst_idx",   g_idx[v],   0);
      check("after_rst_wrap",  g_wrap[v],  0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
